// File: rtl/dds_pkg.sv
// rtl/dds_pkg.sv - shared constants and state type for the DDS waveform-RAM loader
//
// Purpose: default geometry of the DDS bank waveform RAM and the loader FSM
// state encoding, imported by the loader top.
package dds_pkg;

    localparam int N_CHANNELS  = 12;
    localparam int WAVE_ADDR_W = 10;
    localparam int WAVE_DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        FINISH = 2'd2
    } state_e;

endpackage

// File: rtl/dds_wave_loader_if.sv
// rtl/dds_wave_loader_if.sv - ready/valid sample stream feeding the waveform loader
//
// Purpose: bundles the sample stream between the host side and the loader.
// Signals:
//   In_Data   sample word, driven by the source
//   In_Valid  sample present, driven by the source
//   In_Ready  loader can take a sample, driven by the sink
// Modports: master = stream source, slave = loader (sink).
interface dds_wave_loader_if #(
    parameter int DATA_W = 16
);

    logic [DATA_W-1:0] In_Data;
    logic              In_Valid;
    logic              In_Ready;

    modport master (
        output In_Data,
        output In_Valid,
        input  In_Ready
    );

    modport slave (
        input  In_Data,
        input  In_Valid,
        output In_Ready
    );

endinterface

// File: rtl/dds_wave_loader.sv
// rtl/dds_wave_loader.sv - writes a sample stream into the DDS bank waveform RAMs
//
// Purpose: accepts a load request (channel mask + length), then takes that
// many samples from the stream and issues one registered RAM write per
// accepted sample, addresses counting up from 0, while keeping a running
// mod-2**DATA_W checksum of the written words.
// Ports:
//   Clk           clock, also the bank RAM_Clk
//   Reset         synchronous active-high reset
//   Start         load request (one cycle)
//   Channel_Mask  channels to write, captured with an accepted Start
//   Length        sample count 1..2**ADDR_W, captured with an accepted Start
//   Abort         stop the load in progress
//   s_stream      sample stream (slave side)
//   RAM_Data      write data to the bank
//   RAM_Address   write address to the bank
//   RAM_Write     per-channel write enables
//   Busy          loading in progress
//   Done          pulse with the final write of a completed load
//   Error         pulse the cycle after a rejected Start
//   Checksum      sum of words written in the last/current load
module dds_wave_loader
    import dds_pkg::*;
#(
    parameter int N      = N_CHANNELS,
    parameter int ADDR_W = WAVE_ADDR_W,
    parameter int DATA_W = WAVE_DATA_W
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Start,
    input  logic [N-1:0]      Channel_Mask,
    input  logic [ADDR_W:0]   Length,
    input  logic              Abort,
    dds_wave_loader_if.slave  s_stream,
    output logic [DATA_W-1:0] RAM_Data,
    output logic [ADDR_W-1:0] RAM_Address,
    output logic [N-1:0]      RAM_Write,
    output logic              Busy,
    output logic              Done,
    output logic              Error,
    output logic [DATA_W-1:0] Checksum
);

    localparam logic [ADDR_W:0] DEPTH   = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

    state_e              state_q, state_d;
    logic [N-1:0]        mask_q, mask_d;
    logic [ADDR_W:0]     len_q, len_d;
    logic [ADDR_W:0]     cnt_q, cnt_d;
    logic [DATA_W-1:0]   sum_q, sum_d;
    logic [DATA_W-1:0]   ram_data_q, ram_data_d;
    logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
    logic [N-1:0]        ram_write_q, ram_write_d;
    logic                in_ready_q, in_ready_d;
    logic                error_q, error_d;

    logic                params_ok;
    logic                accept;
    logic                handshake;
    logic                last_sample;

    assign params_ok   = (Channel_Mask != '0) && (Length != '0) && (Length <= DEPTH);
    assign accept      = (state_q == IDLE) && Start && params_ok;
    // Abort suppresses the coincident handshake so that sample is never written.
    assign handshake   = (state_q == LOAD) && in_ready_q && s_stream.In_Valid && !Abort;
    assign last_sample = (cnt_q == (len_q - CNT_ONE));

    // State register
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (Abort) begin
                    state_d = IDLE;
                end else if (handshake && last_sample) begin
                    state_d = FINISH;
                end
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath next values
    always_comb begin
        mask_d      = mask_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        sum_d       = sum_q;
        ram_data_d  = ram_data_q;
        ram_addr_d  = ram_addr_q;
        ram_write_d = '0;
        // Any Start that does not launch a load is reported, including one
        // that arrives while a load is still running or finishing.
        error_d     = Start && !accept;
        // Ready follows the state we are about to be in, so it rises with
        // entry into LOAD and falls together with the last accepted sample.
        in_ready_d  = (state_d == LOAD);

        if (accept) begin
            mask_d = Channel_Mask;
            len_d  = Length;
            cnt_d  = '0;
            sum_d  = '0;
        end

        if (handshake) begin
            ram_data_d  = s_stream.In_Data;
            ram_addr_d  = cnt_q[ADDR_W-1:0];
            ram_write_d = mask_q;
            sum_d       = sum_q + s_stream.In_Data;
            cnt_d       = cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            mask_q      <= '0;
            len_q       <= '0;
            cnt_q       <= '0;
            sum_q       <= '0;
            ram_data_q  <= '0;
            ram_addr_q  <= '0;
            ram_write_q <= '0;
            in_ready_q  <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            mask_q      <= mask_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            sum_q       <= sum_d;
            ram_data_q  <= ram_data_d;
            ram_addr_q  <= ram_addr_d;
            ram_write_q <= ram_write_d;
            in_ready_q  <= in_ready_d;
            error_q     <= error_d;
        end
    end

    // Output logic
    always_comb begin
        Busy = (state_q == LOAD);
        // The final write was registered on the way into FINISH, so Done
        // lines up with it.
        Done = (state_q == FINISH);
    end

    assign s_stream.In_Ready = in_ready_q;
    assign RAM_Data          = ram_data_q;
    assign RAM_Address       = ram_addr_q;
    assign RAM_Write         = ram_write_q;
    assign Error             = error_q;
    assign Checksum          = sum_q;

endmodule

// File: tb/tb_dds_wave_loader.sv
// tb/tb_dds_wave_loader.sv - randomized self-checking bench for dds_wave_loader
module tb_dds_wave_loader;

    logic        clk;
    logic        Reset;
    logic        Start;
    logic [11:0] Channel_Mask;
    logic [10:0] Length;
    logic        Abort;
    logic [15:0] RAM_Data;
    logic [9:0]  RAM_Address;
    logic [11:0] RAM_Write;
    logic        Busy;
    logic        Done;
    logic        Error;
    logic [15:0] Checksum;

    dds_wave_loader_if #(.DATA_W(16)) s_if ();

    dds_wave_loader #(.N(12), .ADDR_W(10), .DATA_W(16)) dut (
        .Clk          (clk),
        .Reset        (Reset),
        .Start        (Start),
        .Channel_Mask (Channel_Mask),
        .Length       (Length),
        .Abort        (Abort),
        .s_stream     (s_if),
        .RAM_Data     (RAM_Data),
        .RAM_Address  (RAM_Address),
        .RAM_Write    (RAM_Write),
        .Busy         (Busy),
        .Done         (Done),
        .Error        (Error),
        .Checksum     (Checksum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [9:0]  addr;
        logic [15:0] data;
        logic [11:0] mask;
        logic        done;
    } wr_t;

    wr_t         wr_q[$];
    int          done_cnt = 0;
    int          err_cnt  = 0;
    int          lat_err  = 0;
    bit          hs_prev  = 1'b0;
    logic [15:0] samples[1024];

    int wr_base, done_base, err_base, lat_base;
    int n_tests = 0;
    int n_fail  = 0;

    // Passive monitor: logs every write and pulse, and checks that a write
    // appears exactly one cycle after each accepted (non-aborted) sample.
    always @(negedge clk) begin
        if (RAM_Write != '0) begin
            wr_q.push_back('{addr: RAM_Address, data: RAM_Data, mask: RAM_Write, done: Done});
        end
        if (Done)  done_cnt++;
        if (Error) err_cnt++;
        if ((RAM_Write != '0) != hs_prev) lat_err++;
        hs_prev = s_if.In_Valid && s_if.In_Ready && !Abort && !Reset;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_tests++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic snap();
        wr_base   = wr_q.size();
        done_base = done_cnt;
        err_base  = err_cnt;
        lat_base  = lat_err;
    endtask

    task automatic fill_samples();
        for (int i = 0; i < 1024; i++) samples[i] = 16'($urandom);
    endtask

    task automatic settle();
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic start_load(input logic [11:0] mask, input int len);
        @(posedge clk);
        #1;
        Start        = 1'b1;
        Channel_Mask = mask;
        Length       = 11'(len);
        @(posedge clk);
        #1;
        Start = 1'b0;
    endtask

    // Offers samples[0..n-1] in order, holding each until taken.
    // mode: 0 = valid always, 1 = valid every other cycle, 2 = random valid.
    // abort_idx >= 0 raises Abort together with that sample.
    // start_at >= 0 pulses an extra (rejected) Start on that stream cycle.
    task automatic run_stream(input int n, input int mode, input int abort_idx, input int start_at);
        int idx = 0;
        int cyc = 0;
        bit tog = 1'b1;
        bit v;
        bit stop = 1'b0;
        while (!stop && idx < n && cyc < 8000) begin
            @(posedge clk);
            #1;
            cyc++;
            case (mode)
                0:       v = 1'b1;
                1:       begin v = tog; tog = ~tog; end
                default: v = 1'($urandom_range(0, 1));
            endcase
            s_if.In_Valid = v;
            s_if.In_Data  = samples[idx];
            Abort         = v && (idx == abort_idx);
            if (cyc == start_at) begin
                Start        = 1'b1;
                Channel_Mask = 12'h0F0;
                Length       = 11'd4;
            end else begin
                Start = 1'b0;
            end
            @(negedge clk);
            if (Abort) stop = 1'b1;
            else if (v && s_if.In_Ready) idx++;
        end
        check_eq("stream_budget", 32'(cyc < 8000), 32'd1);
        @(posedge clk);
        #1;
        s_if.In_Valid = 1'b0;
        Abort         = 1'b0;
        Start         = 1'b0;
    endtask

    // Reference: the first exp_n offered samples land at addresses 0..exp_n-1
    // with the load's mask; Done rides on the last write only for a full load.
    task automatic check_load(input string tag, input logic [11:0] mask, input int exp_n,
                              input bit exp_done, input int exp_err);
        int n_w;
        int bad = 0;
        int done_at = -1;
        logic [15:0] sum = '0;
        wr_t w;
        n_w = wr_q.size() - wr_base;
        check_eq({tag, "_nwr"}, 32'(n_w), 32'(exp_n));
        for (int i = 0; i < n_w && i < exp_n; i++) begin
            w = wr_q[wr_base + i];
            if (w.addr != 10'(i) || w.data != samples[i] || w.mask != mask) bad++;
            if (w.done) done_at = i;
        end
        for (int i = 0; i < exp_n; i++) sum = sum + samples[i];
        check_eq({tag, "_content"}, 32'(bad), 32'd0);
        check_eq({tag, "_done_cnt"}, 32'(done_cnt - done_base), 32'(exp_done));
        check_eq({tag, "_done_pos"}, 32'(done_at), exp_done ? 32'(exp_n - 1) : 32'hFFFF_FFFF);
        check_eq({tag, "_checksum"}, 32'(Checksum), 32'(sum));
        check_eq({tag, "_busy"}, 32'(Busy), 32'd0);
        check_eq({tag, "_ready"}, 32'(s_if.In_Ready), 32'd0);
        check_eq({tag, "_err"}, 32'(err_cnt - err_base), 32'(exp_err));
        check_eq({tag, "_latency"}, 32'(lat_err - lat_base), 32'd0);
    endtask

    initial begin
        int          cyc;
        bit          hit;
        logic [11:0] m;
        int          len;
        int          mode;
        int          ab;

        Reset         = 1'b1;
        Start         = 1'b0;
        Channel_Mask  = '0;
        Length        = '0;
        Abort         = 1'b0;
        s_if.In_Valid = 1'b0;
        s_if.In_Data  = '0;

        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_ready", 32'(s_if.In_Ready), 32'd0);
        check_eq("rst_busy", 32'(Busy), 32'd0);
        check_eq("rst_done", 32'(Done), 32'd0);
        check_eq("rst_error", 32'(Error), 32'd0);
        check_eq("rst_write", 32'(RAM_Write), 32'd0);
        check_eq("rst_data", 32'(RAM_Data), 32'd0);
        check_eq("rst_addr", 32'(RAM_Address), 32'd0);
        check_eq("rst_checksum", 32'(Checksum), 32'd0);
        Reset = 1'b0;

        // Basic four-word load on channel 0
        for (int i = 0; i < 1024; i++) samples[i] = 16'(i + 1);
        snap();
        start_load(12'h001, 4);
        run_stream(4, 0, -1, -1);
        settle();
        check_load("t1", 12'h001, 4, 1'b1, 0);
        check_eq("t1_sum_const", 32'(Checksum), 32'h000A);

        // Full-depth load, valid toggling
        fill_samples();
        snap();
        start_load(12'hFFF, 1024);
        run_stream(1024, 1, -1, -1);
        settle();
        check_load("t2", 12'hFFF, 1024, 1'b1, 0);

        // Rejected starts
        snap();
        start_load(12'h000, 4);
        check_eq("t3_busy_mask0", 32'(Busy), 32'd0);
        start_load(12'h001, 0);
        check_eq("t3_busy_len0", 32'(Busy), 32'd0);
        start_load(12'h001, 1025);
        check_eq("t3_busy_len1025", 32'(Busy), 32'd0);
        settle();
        check_eq("t3_err", 32'(err_cnt - err_base), 32'd3);
        check_eq("t3_nwr", 32'(wr_q.size() - wr_base), 32'd0);

        // Abort together with the fifth sample
        fill_samples();
        snap();
        start_load(12'h5A5, 8);
        run_stream(8, 0, 4, -1);
        settle();
        check_load("t4", 12'h5A5, 4, 1'b0, 0);

        // Start pulsed in the middle of a load
        fill_samples();
        snap();
        start_load(12'h0C3, 8);
        run_stream(8, 0, -1, 3);
        settle();
        check_load("t5", 12'h0C3, 8, 1'b1, 1);

        // Reset during the third write
        snap();
        start_load(12'h00F, 6);
        cyc = 0;
        hit = 1'b0;
        while (!hit && cyc < 50) begin
            @(posedge clk);
            #1;
            cyc++;
            s_if.In_Valid = 1'b1;
            s_if.In_Data  = 16'($urandom);
            if (RAM_Write != '0 && RAM_Address == 10'd2) begin
                Reset = 1'b1;
                hit   = 1'b1;
            end
        end
        check_eq("t6_third_write_seen", 32'(hit), 32'd1);
        @(posedge clk);
        #1;
        check_eq("t6_write", 32'(RAM_Write), 32'd0);
        check_eq("t6_busy", 32'(Busy), 32'd0);
        check_eq("t6_ready", 32'(s_if.In_Ready), 32'd0);
        check_eq("t6_checksum", 32'(Checksum), 32'd0);
        Reset         = 1'b0;
        s_if.In_Valid = 1'b0;
        fill_samples();
        snap();
        start_load(12'h801, 6);
        run_stream(6, 2, -1, -1);
        settle();
        check_load("t6b", 12'h801, 6, 1'b1, 0);

        // Single-sample load and abort on the last sample
        fill_samples();
        snap();
        start_load(12'h010, 1);
        run_stream(1, 2, -1, -1);
        settle();
        check_load("len1", 12'h010, 1, 1'b1, 0);

        fill_samples();
        snap();
        start_load(12'h3C0, 5);
        run_stream(5, 2, 4, -1);
        settle();
        check_load("abort_last", 12'h3C0, 4, 1'b0, 0);

        // Randomized loads
        for (int r = 0; r < 10; r++) begin
            m    = 12'($urandom_range(1, 4095));
            len  = $urandom_range(1, 40);
            mode = $urandom_range(0, 2);
            ab   = ($urandom_range(0, 2) == 0) ? $urandom_range(0, len - 1) : -1;
            fill_samples();
            snap();
            start_load(m, len);
            run_stream(len, mode, ab, -1);
            settle();
            check_load("rnd", m, (ab >= 0) ? ab : len, ab < 0, 0);
        end

        check_eq("latency_total", 32'(lat_err), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
